// File: rtl/div_result_bcd_fmt.sv
// div_result_bcd_fmt: converts packed divider {remainder, quotient} to 3-digit BCD
// with a one-step-per-clock double-dabble; divide-by-zero bypasses conversion.
module div_result_bcd_fmt #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2*DW-1:0] in_result,
    input  logic          in_dbz,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [11:0]   quot_bcd,
    output logic [11:0]   rem_bcd,
    output logic          out_err
);
    localparam int CW = $clog2(DW + 1);
    localparam int SW = 12 + DW;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state, next;
    logic [SW-1:0] qsr, rsr, q_step, r_step;
    logic [CW-1:0] cnt;
    logic          accept, last_step;

    // BCD digits sit above the binary bits still waiting to be shifted in
    function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] v);
        logic [SW-1:0] t;
        t = v;
        for (int i = 0; i < 3; i++)
            if (t[DW+4*i +: 4] >= 4'd5) t[DW+4*i +: 4] = t[DW+4*i +: 4] + 4'd3;
        return {t[SW-2:0], 1'b0};
    endfunction

    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign last_step = state == CONV && cnt == CW'(1);
    assign q_step    = dd_step(qsr);
    assign r_step    = dd_step(rsr);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        if (accept)                         next = in_dbz ? DONE : CONV;
        else if (last_step)                 next = DONE;
        else if (state == DONE && out_ready) next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            qsr      <= '0;
            rsr      <= '0;
            quot_bcd <= '0;
            rem_bcd  <= '0;
            out_err  <= 1'b0;
        end else if (accept) begin
            if (in_dbz) begin
                quot_bcd <= '0;
                rem_bcd  <= '0;
                out_err  <= 1'b1;
            end else begin
                qsr <= {12'h000, in_result[DW-1:0]};
                rsr <= {12'h000, in_result[2*DW-1:DW]};
                cnt <= CW'(DW);
            end
        end else if (state == CONV) begin
            qsr <= q_step;
            rsr <= r_step;
            cnt <= cnt - 1'b1;
            if (last_step) begin
                quot_bcd <= q_step[SW-1:DW];
                rem_bcd  <= r_step[SW-1:DW];
                out_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_result_bcd_fmt.sv
// tb_div_result_bcd_fmt: scoreboard bench; expected BCD comes from decimal arithmetic
// on each accepted input, a negedge monitor pops and compares on every out handshake.
module tb_div_result_bcd_fmt;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*DW-1:0] in_result = '0;
    logic          in_dbz = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [11:0]   quot_bcd, rem_bcd;
    logic          out_err;

    int            n_chk = 0, n_err = 0, n_acc = 0;
    logic          last_acc = 1'b0;
    logic [24:0]   sb[$];
    logic          hold = 1'b0;
    logic [24:0]   prev = '0;

    div_result_bcd_fmt #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_dbz(in_dbz), .out_valid(out_valid),
        .out_ready(out_ready), .quot_bcd(quot_bcd), .rem_bcd(rem_bcd), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [24:0] model(input logic [2*DW-1:0] r, input logic d);
        int q, m;
        q = int'(r) % (1 << DW);
        m = int'(r) / (1 << DW);
        return d ? {1'b1, 24'h0} : {1'b0, to_bcd(q), to_bcd(m)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: detect an accept just before the edge, then step past the edge
    task automatic cyc();
        @(negedge clk);
        last_acc = rst_n && in_valid && in_ready;
        if (last_acc) begin
            sb.push_back(model(in_result, in_dbz));
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (last_acc) in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_edges);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("edges_to_valid", k, exp_edges);
    endtask

    task automatic send(input logic [2*DW-1:0] r, input logic d);
        int k;
        in_valid = 1'b1;
        in_result = r;
        in_dbz = d;
        k = 0;
        last_acc = 1'b0;
        while (!last_acc && k < 50) begin
            cyc();
            k++;
        end
        chk("accept_timeout", {31'b0, last_acc}, 1);
        wait_valid(d ? 0 : DW);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", {31'b0, out_valid}, 1);
                chk("hold_data", {7'b0, out_err, quot_bcd, rem_bcd}, {7'b0, prev});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else chk("out_data", {7'b0, out_err, quot_bcd, rem_bcd}, {7'b0, sb.pop_front()});
            end
            hold = out_valid && !out_ready;
            prev = {out_err, quot_bcd, rem_bcd};
        end
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_data", {7'b0, out_err, quot_bcd, rem_bcd}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        rst_n = 1'b1;
        send(8'h38, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        send(8'hA7, 1'b1);
        cyc();
        // backpressure: hold the first result while a second input waits
        out_ready = 1'b0;
        send(8'h38, 1'b0);
        in_valid = 1'b1;
        in_result = 8'h29;
        in_dbz = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_same_edge_accept", {31'b0, last_acc}, 1);
        wait_valid(DW - 0);
        cyc();
        // reset in the middle of a conversion discards it
        in_valid = 1'b1;
        in_result = 8'h38;
        in_dbz = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 0);
        rst_n = 1'b1;
        chk("midrst_in_ready", {31'b0, in_ready}, 1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_out", {31'b0, out_valid}, 0);
            cyc();
        end
        send(8'h38, 1'b0);
        cyc();
        // random stream with random backpressure
        n_acc = 0;
        k = 0;
        while (n_acc < 200 && k < 20000) begin
            if (!in_valid && $urandom_range(1, 0) == 1) begin
                in_valid = 1'b1;
                in_result = (2*DW)'($urandom);
                in_dbz = $urandom_range(7, 0) == 0;
            end
            out_ready = $urandom_range(1, 0) == 1;
            cyc();
            k++;
        end
        chk("stream_accepts", n_acc, 200);
        in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            cyc();
            k++;
        end
        chk("drain_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
